// File: rtl/ifu_fetch_queue_if.sv
// Handshake bundle between the PC generator, instruction arbiter and decode.
// The queue side uses modport slave; the surrounding pipeline uses master.
interface ifu_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid_i;
  logic              pc_ready_o;
  logic              flush_i;

  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [DATA_W-1:0] mem_rsp_data_i;
  logic              mem_rsp_valid_i;
  logic              mem_rsp_ready_o;

  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_err_o;
  logic              inst_valid_o;
  logic              inst_ready_i;

  modport slave (
    input  pc_i, pc_valid_i, flush_i, mem_req_ready_i, mem_rsp_data_i,
           mem_rsp_valid_i, inst_ready_i,
    output pc_ready_o, mem_req_addr_o, mem_req_valid_o, mem_rsp_ready_o,
           inst_o, inst_pc_o, inst_err_o, inst_valid_o
  );

  modport master (
    output pc_i, pc_valid_i, flush_i, mem_req_ready_i, mem_rsp_data_i,
           mem_rsp_valid_i, inst_ready_i,
    input  pc_ready_o, mem_req_addr_o, mem_req_valid_o, mem_rsp_ready_o,
           inst_o, inst_pc_o, inst_err_o, inst_valid_o
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// In-order multi-outstanding instruction fetch queue with flush-kill draining.
// Define IFU_FETCH_PERF_EN to add 64-bit fetch/kill/stall performance counters.
module ifu_fetch_queue #(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 64,
  parameter int              INST_W = 32,
  parameter int              DEPTH  = 4,
  parameter logic [ADDR_W-1:0] MBASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] MEND  = 32'h8800_0000
) (
  input  logic                clk,
  input  logic                rst,
  ifu_fetch_queue_if.slave    bus
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [63:0]         perf_fetch_cnt_o,
  output logic [63:0]         perf_kill_cnt_o,
  output logic [63:0]         perf_stall_cnt_o
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LANES  = DATA_W / INST_W;
  localparam int INST_B = $clog2(INST_W / 8);

  typedef logic [PTR_W:0] ptr_t;

  ptr_t alloc_ptr, fill_ptr, head_ptr, count;
  logic [PTR_W-1:0] alloc_idx, fill_idx, head_idx;

  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [INST_W-1:0] lane_q [DEPTH];
  logic [DEPTH-1:0]  filled_q, kill_q, err_q, occupied;

  logic full, empty, req_valid, req_fire, rsp_fire, pc_err;
  logic out_valid, drop, pop;

  // Picks the instruction lane addressed by the low PC bits within the response beat.
  function automatic logic [INST_W-1:0] pick_lane(input logic [DATA_W-1:0] data,
                                                  input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-1:0] idx;
    idx = (pc >> INST_B) & ADDR_W'(LANES - 1);
    return INST_W'(data >> (idx * INST_W));
  endfunction

  assign alloc_idx = alloc_ptr[PTR_W-1:0];
  assign fill_idx  = fill_ptr[PTR_W-1:0];
  assign head_idx  = head_ptr[PTR_W-1:0];
  assign count     = alloc_ptr - head_ptr;
  assign empty     = (alloc_ptr == head_ptr);
  assign full      = (alloc_ptr[PTR_W] != head_ptr[PTR_W]) && (alloc_idx == head_idx);

  // Request path is purely combinational; reset gates it so nothing leaks out mid-reset.
  assign req_valid = rst & bus.pc_valid_i & ~full & ~bus.flush_i;
  assign req_fire  = req_valid & bus.mem_req_ready_i;
  assign pc_err    = (bus.pc_i < MBASE) || (bus.pc_i >= MEND);

  assign bus.mem_req_addr_o  = bus.pc_i;
  assign bus.mem_req_valid_o = req_valid;
  assign bus.pc_ready_o      = req_fire;
  assign bus.mem_rsp_ready_o = rst;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_fire = rst & bus.mem_rsp_valid_i & (fill_ptr != alloc_ptr);

  assign out_valid = ~empty & filled_q[head_idx] & ~kill_q[head_idx] & ~bus.flush_i;
  assign drop      = ~empty & filled_q[head_idx] & kill_q[head_idx];
  assign pop       = (out_valid & bus.inst_ready_i) | drop;

  assign bus.inst_valid_o = out_valid;
  assign bus.inst_o       = lane_q[head_idx];
  assign bus.inst_pc_o    = pc_q[head_idx];
  assign bus.inst_err_o   = err_q[head_idx];

  // NOTE: default first so every path assigns occupied and no latch is inferred.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = ptr_t'({1'b0, PTR_W'(i) - head_idx}) < count;
    end
  end

  // NOTE: non-blocking assignments keep every register update order-independent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      filled_q  <= '0;
      kill_q    <= '0;
      err_q     <= '0;
    end else begin
      if (req_fire) begin
        filled_q[alloc_idx] <= 1'b0;
        kill_q[alloc_idx]   <= 1'b0;
        err_q[alloc_idx]    <= pc_err;
        alloc_ptr           <= alloc_ptr + ptr_t'(1);
      end
      if (rsp_fire) begin
        filled_q[fill_idx] <= 1'b1;
        fill_ptr           <= fill_ptr + ptr_t'(1);
      end
      // Flush never coincides with an alloc, so this cannot clash with the clear above.
      if (bus.flush_i) kill_q <= kill_q | occupied;
      if (pop)         head_ptr <= head_ptr + ptr_t'(1);
    end
  end

  // NOTE: payload storage is not reset; filled/kill and the pointers guard every read.
  always_ff @(posedge clk) begin
    if (req_fire) pc_q[alloc_idx]  <= bus.pc_i;
    if (rsp_fire) lane_q[fill_idx] <= pick_lane(bus.mem_rsp_data_i, pc_q[fill_idx]);
  end

`ifdef IFU_FETCH_PERF_EN
  logic [63:0] fetch_cnt, kill_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      kill_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid & bus.inst_ready_i)   fetch_cnt <= fetch_cnt + 64'd1;
      if (drop)                           kill_cnt  <= kill_cnt + 64'd1;
      if (bus.pc_valid_i & ~req_fire)     stall_cnt <= stall_cnt + 64'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt;
  assign perf_kill_cnt_o  = kill_cnt;
  assign perf_stall_cnt_o = stall_cnt;
`endif

  rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_rsp_valid_i |-> (fill_ptr != alloc_ptr));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed testbench for ifu_fetch_queue: in-order arbiter model plus per-scenario checks.
module tb_ifu_fetch_queue;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(INST_W)) bus ();

`ifdef IFU_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_kill_cnt, perf_stall_cnt;
`endif

  ifu_fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(INST_W), .DEPTH(DEPTH),
    .MBASE(32'h8000_0000), .MEND(32'h8800_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFU_FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_kill_cnt_o  (perf_kill_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    int          cyc;
  } rec_t;

  rec_t        got[$];
  logic [31:0] mq[$];
  int          rsp_done    = 0;
  int          rsp_allowed = 0;

  // Memory image: every 32-bit word holds its own byte address XOR a fixed pattern.
  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Delivered-instruction monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && bus.inst_valid_o && bus.inst_ready_i)
      got.push_back('{bus.inst_pc_o, bus.inst_o, bus.inst_err_o, cyc});
  end

  // In-order arbiter: records handshakes mid-cycle, presents responses after each edge.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
    end else begin
      if (bus.mem_rsp_valid_i && bus.mem_rsp_ready_o) begin
        void'(mq.pop_front());
        rsp_done++;
      end
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) mq.push_back(bus.mem_req_addr_o);
    end
  end

  initial begin
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst && rsp_done < rsp_allowed && mq.size() > 0) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = {exp_inst({mq[0][31:3], 3'b100}), exp_inst({mq[0][31:3], 3'b000})};
      end else begin
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pc(input logic [31:0] a);
    int n = 0;
    @(posedge clk); #1;
    bus.pc_i       = a;
    bus.pc_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.pc_ready_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.pc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL push_pc accept %h: pc_ready_o=%b required 1", a, bus.pc_ready_o);
    end
  endtask

  task automatic idle_pc();
    @(posedge clk); #1;
    bus.pc_valid_i = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got.size() != n) begin
      errors++;
      $display("FAIL delivered count: got %0d required %0d", got.size(), n);
    end
  endtask

  task automatic check_rec(input string name, input int idx,
                           input logic [31:0] pc, input logic err);
    checks++;
    if (idx >= got.size()) begin
      errors++;
      $display("FAIL %s[%0d]: missing, required pc %h", name, idx, pc);
    end else if (got[idx].pc !== pc || got[idx].inst !== exp_inst(pc) || got[idx].err !== err) begin
      errors++;
      $display("FAIL %s[%0d]: got pc %h inst %h err %b required pc %h inst %h err %b",
               name, idx, got[idx].pc, got[idx].inst, got[idx].err, pc, exp_inst(pc), err);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.mem_req_valid_o !== 1'b0 || bus.pc_ready_o !== 1'b0 ||
        bus.inst_valid_o !== 1'b0 || bus.mem_rsp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: req_valid %b pc_ready %b inst_valid %b rsp_ready %b required 0 0 0 0",
               bus.mem_req_valid_o, bus.pc_ready_o, bus.inst_valid_o, bus.mem_rsp_ready_o);
    end
    @(posedge clk); #1;
    rst            = 1'b1;
    bus.pc_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_rsp_ready_o !== 1'b1 || bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post-reset: rsp_ready %b inst_valid %b required 1 0",
               bus.mem_rsp_ready_o, bus.inst_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs   [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    logic [31:0] insts [4] = '{32'hDA5A_5A5A, 32'hDA5A_5A5E, 32'hDA5A_5A52, 32'hDA5A_5A56};
    int b = got.size();
    rsp_allowed = 1 << 30;
    for (int i = 0; i < 4; i++) push_pc(pcs[i]);
    idle_pc();
    wait_got(b + 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b + i >= got.size()) begin
        errors++;
        $display("FAIL b2b[%0d]: missing", i);
      end else if (got[b+i].pc !== pcs[i] || got[b+i].inst !== insts[i] ||
                   got[b+i].cyc != got[b].cyc + i) begin
        errors++;
        $display("FAIL b2b[%0d]: got pc %h inst %h cyc+%0d required pc %h inst %h cyc+%0d",
                 i, got[b+i].pc, got[b+i].inst, got[b+i].cyc - got[b].cyc, pcs[i], insts[i], i);
      end
    end
  endtask

  task automatic test_full();
    int b = got.size();
    rsp_allowed = rsp_done;
    for (int i = 0; i < 4; i++) push_pc(32'h8000_0020 + 32'(4 * i));
    @(posedge clk); #1;
    bus.pc_i = 32'h8000_0030;
    @(negedge clk);
    checks++;
    if (bus.pc_ready_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL full block: pc_ready %b req_valid %b required 0 0", bus.pc_ready_o, bus.mem_req_valid_o);
    end
    @(posedge clk); #1;
    rsp_allowed = rsp_done + 1;
    @(negedge clk);
    checks++;
    if (bus.pc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full rsp cycle: pc_ready %b required 0", bus.pc_ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h8000_0020 || bus.pc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full pop cycle: inst_valid %b inst_pc %h pc_ready %b required 1 80000020 0",
               bus.inst_valid_o, bus.inst_pc_o, bus.pc_ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.pc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full release: pc_ready %b required 1", bus.pc_ready_o);
    end
    idle_pc();
    rsp_allowed = 1 << 30;
    wait_got(b + 5);
    for (int i = 0; i < 5; i++) check_rec("full", b + i, 32'h8000_0020 + 32'(4 * i), 1'b0);
  endtask

  task automatic test_flush();
    int b = got.size();
    rsp_allowed = rsp_done;
    for (int i = 0; i < 3; i++) push_pc(32'h8000_0060 + 32'(4 * i));
    @(posedge clk); #1;
    bus.pc_i    = 32'h8000_0100;
    bus.flush_i = 1'b1;
    rsp_allowed = rsp_done + 1;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid_o !== 1'b0 || bus.pc_ready_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush cycle: req_valid %b pc_ready %b inst_valid %b required 0 0 0",
               bus.mem_req_valid_o, bus.pc_ready_o, bus.inst_valid_o);
    end
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    rsp_allowed = 1 << 30;
    @(negedge clk);
    checks++;
    if (bus.pc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush next accept: pc_ready %b required 1", bus.pc_ready_o);
    end
    idle_pc();
    wait_got(b + 1);
    check_rec("flush", b, 32'h8000_0100, 1'b0);
  endtask

  task automatic test_stall();
    int b = got.size();
    rsp_allowed      = 1 << 30;
    bus.inst_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_pc(32'h8000_0080 + 32'(4 * i));
    @(posedge clk); #1;
    bus.pc_i = 32'h8000_0090;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h8000_0080 ||
          bus.inst_o !== 32'hDA5A_5ADA || bus.pc_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall hold %0d: inst_valid %b inst_pc %h inst %h pc_ready %b required 1 80000080 da5a5ada 0",
                 i, bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, bus.pc_ready_o);
      end
    end
    @(posedge clk); #1;
    bus.inst_ready_i = 1'b1;
    push_pc(32'h8000_0090);
    idle_pc();
    wait_got(b + 5);
    for (int i = 0; i < 5; i++) check_rec("stall", b + i, 32'h8000_0080 + 32'(4 * i), 1'b0);
  endtask

  task automatic test_illegal_pc();
    logic [31:0] pcs  [5] = '{32'h0000_1000, 32'h8000_0000, 32'h7FFF_FFFC, 32'h87FF_FFFC, 32'h8800_0000};
    logic        errs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int b = got.size();
    rsp_allowed = 1 << 30;
    for (int i = 0; i < 5; i++) push_pc(pcs[i]);
    idle_pc();
    wait_got(b + 5);
    for (int i = 0; i < 5; i++) check_rec("illegal", b + i, pcs[i], errs[i]);
  endtask

  task automatic test_async_reset();
    int b = got.size();
    bus.inst_ready_i = 1'b0;
    rsp_allowed      = rsp_done + 1;
    push_pc(32'h8000_0200);
    push_pc(32'h8000_0204);
    idle_pc();
    @(negedge clk);
    checks++;
    if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h8000_0200) begin
      errors++;
      $display("FAIL pre-reset head: inst_valid %b inst_pc %h required 1 80000200",
               bus.inst_valid_o, bus.inst_pc_o);
    end
    @(posedge clk); #1;
    bus.pc_i       = 32'h8000_0208;
    bus.pc_valid_i = 1'b1;
    rsp_allowed    = rsp_done;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0 ||
        bus.pc_ready_o !== 1'b0 || bus.mem_rsp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL async reset: inst_valid %b req_valid %b pc_ready %b rsp_ready %b required 0 0 0 0",
               bus.inst_valid_o, bus.mem_req_valid_o, bus.pc_ready_o, bus.mem_rsp_ready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.mem_rsp_ready_o !== 1'b1 || bus.pc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL after async reset: inst_valid %b rsp_ready %b pc_ready %b required 0 1 1",
               bus.inst_valid_o, bus.mem_rsp_ready_o, bus.pc_ready_o);
    end
    @(posedge clk); #1;
    bus.pc_valid_i   = 1'b0;
    bus.inst_ready_i = 1'b1;
    rsp_allowed      = 1 << 30;
    wait_got(b + 1);
    check_rec("reset refetch", b, 32'h8000_0208, 1'b0);
  endtask

  initial begin
    bus.pc_i            = 32'h8000_0000;
    bus.pc_valid_i      = 1'b1;
    bus.flush_i         = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    bus.inst_ready_i    = 1'b1;

    test_reset();
    test_back_to_back();
    test_full();
    test_flush();
    test_stall();
    test_illegal_pc();
    test_async_reset();

`ifdef IFU_FETCH_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 64'd1) begin
      errors++;
      $display("FAIL perf fetch count: got %0d required 1", perf_fetch_cnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
